// File: rtl/combination_code_sequencer.sv
// combination_code_sequencer
// Replays a latched 3-code combination into a 3-step combination lock as timed
// Key1/Key2 presses with Password held stable, checks the lock's thermometer
// status after each step, and retries from step 0 when the lock falls back to
// its start state.
// Optional feature: define ABORT_EN to add an Abort input that abandons a
// sequence in progress.
module combination_code_sequencer #(
   parameter int KEY_HOLD  = 4,
   parameter int KEY_GAP   = 2,
   parameter int MAX_RETRY = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
`ifdef ABORT_EN
   input  logic       Abort,
`endif
   input  logic [3:0] Code0,
   input  logic [3:0] Code1,
   input  logic [3:0] Code2,
   input  logic [3:0] LockStatus,
   output logic       Key1,
   output logic       Key2,
   output logic [3:0] Password,
   output logic       Busy,
   output logic       Done,
   output logic       Fail,
   output logic [1:0] Step,
   output logic [1:0] Retries
);

   localparam int CNT_MAX = (KEY_HOLD > KEY_GAP) ? KEY_HOLD : KEY_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(KEY_HOLD - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(KEY_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PRESS, S_RELEASE, S_CHECK, S_DONE, S_FAIL
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      step_q, step_d;
   logic [1:0]      retries_q, retries_d;
   logic [3:0]      code_q [3];
   logic [3:0]      code_d [3];
   logic [3:0]      expect_status;
   logic            active;
   logic            abort_req;

`ifdef ABORT_EN
   assign abort_req = Abort;
`else
   assign abort_req = 1'b0;
`endif

   // States in which a sequence is in progress.
   assign active = (state_q == S_SETUP) || (state_q == S_PRESS) ||
                   (state_q == S_RELEASE) || (state_q == S_CHECK);

   // State register, hold/gap counter, step/retry counters and latched codes.
   // NOTE: the code store is only three nibbles, so it is cleared on reset like
   // the rest of the state; a large memory would normally be left unreset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         step_q    <= '0;
         retries_q <= '0;
         for (int i = 0; i < 3; i++) code_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         retries_q <= retries_d;
         code_q    <= code_d;
      end
   end

   // Lock status that a correct press at the current step should produce.
   always_comb begin
      case (step_q)
         2'd0:    expect_status = 4'b0011;
         2'd1:    expect_status = 4'b0111;
         default: expect_status = 4'b1111;
      endcase
   end

   // Next-state logic: sequencing, retry decision, abort and counter reload.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d   = state_q;
      step_d    = step_q;
      retries_d = retries_q;
      code_d    = code_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (LockStatus == 4'b1111) begin
                  state_d = S_DONE;
               end else if (LockStatus != 4'b0001) begin
                  state_d = S_FAIL;
               end else begin
                  code_d[0] = Code0;
                  code_d[1] = Code1;
                  code_d[2] = Code2;
                  retries_d = '0;
                  step_d    = '0;
                  state_d   = S_SETUP;
               end
            end
         end
         S_SETUP:   state_d = S_PRESS;
         S_PRESS:   if (cnt_q == '0) state_d = S_RELEASE;
         S_RELEASE: if (cnt_q == '0) state_d = S_CHECK;
         S_CHECK: begin
            if (LockStatus == expect_status) begin
               if (step_q < 2'd2) begin
                  step_d  = step_q + 2'd1;
                  state_d = S_SETUP;
               end else begin
                  state_d = S_DONE;
               end
            end else if ((LockStatus == 4'b0001) && (int'(retries_q) < MAX_RETRY)) begin
               retries_d = retries_q + 2'd1;
               step_d    = '0;
               state_d   = S_SETUP;
            end else begin
               state_d = S_FAIL;
            end
         end
         default: state_d = S_IDLE;  // DONE and FAIL last one cycle
      endcase

      // Abort wins over anything CHECK decided on the same edge.
      if (abort_req && active) begin
         state_d   = S_FAIL;
         step_d    = step_q;
         retries_d = retries_q;
      end

      // Counter reloads on every state entry and otherwise runs down to zero.
      if (state_d != state_q) begin
         cnt_d = (state_d == S_PRESS) ? HOLD_LOAD : GAP_LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      Key1     = (state_q == S_PRESS) && (step_q != 2'd1);
      Key2     = (state_q == S_PRESS) && (step_q == 2'd1);
      Busy     = active;
      Done     = (state_q == S_DONE);
      Fail     = (state_q == S_FAIL);
      Step     = step_q;
      Retries  = retries_q;
      Password = '0;
      if (active) begin
         case (step_q)
            2'd0:    Password = code_q[0];
            2'd1:    Password = code_q[1];
            default: Password = code_q[2];
         endcase
      end
   end

endmodule

// File: tb/tb_combination_code_sequencer.sv
// Testbench for combination_code_sequencer: behavioural lock (combination D,7,9),
// per-cycle expected-output scoreboard built from step/attempt arithmetic, and a
// negedge monitor that compares the DUT against it.
module tb_combination_code_sequencer;

   localparam int KEY_HOLD  = 4;
   localparam int KEY_GAP   = 2;
   localparam int MAX_RETRY = 3;
   localparam int STEP_LEN  = 2 + KEY_HOLD + KEY_GAP;

   logic       Clk, Reset, Start;
   logic [3:0] Code0, Code1, Code2, LockStatus;
   logic       Key1, Key2, Busy, Done, Fail;
   logic [3:0] Password;
   logic [1:0] Step, Retries;
`ifdef ABORT_EN
   logic       Abort;
`endif

   combination_code_sequencer #(
      .KEY_HOLD(KEY_HOLD), .KEY_GAP(KEY_GAP), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start),
`ifdef ABORT_EN
      .Abort(Abort),
`endif
      .Code0(Code0), .Code1(Code1), .Code2(Code2), .LockStatus(LockStatus),
      .Key1(Key1), .Key2(Key2), .Password(Password), .Busy(Busy),
      .Done(Done), .Fail(Fail), .Step(Step), .Retries(Retries)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural lock ----------------
   function automatic logic [3:0] comb_code(input int i);
      case (i)
         0:       return 4'hD;
         1:       return 4'h7;
         default: return 4'h9;
      endcase
   endfunction

   int   lock_state;       // 0..3 steps opened
   logic lock_force;
   int   lock_force_val;
   logic k1_prev, k2_prev;

   assign LockStatus = {lock_state >= 3, lock_state >= 2, lock_state >= 1, 1'b1};

   always @(posedge Clk) begin
      k1_prev <= Key1;
      k2_prev <= Key2;
      if (lock_force) begin
         lock_state <= lock_force_val;
      end else if ((Key1 && !k1_prev) || (Key2 && !k2_prev)) begin
         case (lock_state)
            0: lock_state <= (Key1 && Password == comb_code(0)) ? 1 : 0;
            1: lock_state <= (Key2 && Password == comb_code(1)) ? 2 : 0;
            2: lock_state <= (Key1 && Password == comb_code(2)) ? 3 : 0;
            default: lock_state <= lock_state;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic       k1, k2;
      logic [3:0] pw;
      logic       busy, done, fail;
      logic [1:0] step, ret;
      bit         chk_ret;
   } exp_t;

   exp_t wave_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic push_end(input logic d, input logic f, input int ret, input bit chk);
      exp_t e;
      e.k1 = 0; e.k2 = 0; e.pw = 0; e.busy = 0; e.done = d; e.fail = f;
      e.step = 0; e.ret = 2'(ret); e.chk_ret = chk;
      wave_q.push_back(e);
   endtask

   // Expected output per cycle after the Start edge, from the step/attempt rules.
   task automatic predict(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                          input int lock0, input int abort_at);
      logic [3:0] c [3];
      int   bad, t, ret;
      exp_t e;
      c[0] = c0; c[1] = c1; c[2] = c2;
      if (lock0 == 3) begin push_end(1, 0, 0, 0); return; end
      if (lock0 != 0) begin push_end(0, 1, 0, 0); return; end
      bad = 3;
      for (int i = 2; i >= 0; i--) if (c[i] != comb_code(i)) bad = i;
      t = 0; ret = 0;
      while (1) begin
         for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < STEP_LEN; p++) begin
               if (t == abort_at) begin push_end(0, 1, ret, 1); return; end
               e.busy = 1; e.done = 0; e.fail = 0;
               e.pw = c[s]; e.step = 2'(s); e.ret = 2'(ret); e.chk_ret = 1;
               e.k1 = (p >= 1) && (p <= KEY_HOLD) && (s != 1);
               e.k2 = (p >= 1) && (p <= KEY_HOLD) && (s == 1);
               wave_q.push_back(e);
               t++;
            end
            if (t == abort_at) begin push_end(0, 1, ret, 1); return; end
            if (s == bad) begin
               if (ret < MAX_RETRY) begin ret++; break; end
               push_end(0, 1, ret, 1);
               return;
            end
            if (s == 2) begin push_end(1, 0, ret, 1); return; end
         end
      end
   endtask

   // Monitor: one expected entry per cycle while a response is pending, else idle.
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset) begin
         if (wave_q.size() > 0) begin
            e = wave_q.pop_front();
            check("key1",     {3'b0, Key1}, {3'b0, e.k1});
            check("key2",     {3'b0, Key2}, {3'b0, e.k2});
            check("password", Password,     e.pw);
            check("busy",     {3'b0, Busy}, {3'b0, e.busy});
            check("done",     {3'b0, Done}, {3'b0, e.done});
            check("fail",     {3'b0, Fail}, {3'b0, e.fail});
            if (e.busy)    check("step",    {2'b0, Step},    {2'b0, e.step});
            if (e.chk_ret) check("retries", {2'b0, Retries}, {2'b0, e.ret});
         end else begin
            check("idle_busy", {3'b0, Busy}, 4'h0);
            check("idle_keys", {2'b0, Key1, Key2}, 4'h0);
            check("idle_pw",   Password, 4'h0);
            check("idle_pulse", {2'b0, Done, Fail}, 4'h0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_lock(input int s);
      @(negedge Clk);
      lock_force_val = s;
      lock_force     = 1'b1;
      @(posedge Clk);
      #1 lock_force = 1'b0;
   endtask

   task automatic run_seq(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                          input int lock0, input int abort_at, input bit poke);
      int cyc;
      set_lock(lock0);
      @(negedge Clk);
      Code0 = c0; Code1 = c1; Code2 = c2; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      predict(c0, c1, c2, lock0, abort_at);
      cyc = 0;
      while (wave_q.size() > 0 && cyc < 400) begin
         @(negedge Clk);
         cyc++;
         if (poke && cyc == 6)  begin Start = 1'b1; Code1 = 4'h3; Code0 = 4'h1; end
         if (poke && cyc == 7)  Start = 1'b0;
         if (poke && cyc == 12) begin Start = 1'b1; Code2 = 4'h4; end
         if (poke && cyc == 13) Start = 1'b0;
`ifdef ABORT_EN
         if (cyc == abort_at)     Abort = 1'b1;
         if (cyc == abort_at + 1) Abort = 1'b0;
`endif
      end
      if (cyc >= 400) begin
         check("timeout", 4'h1, 4'h0);
         wave_q.delete();
      end
      repeat (2) @(negedge Clk);
   endtask

   initial begin
      logic [3:0] r0, r1, r2;
      int         l0;
      Reset = 1'b1; Start = 1'b0;
      Code0 = '0; Code1 = '0; Code2 = '0;
      lock_force = 1'b0; lock_force_val = 0; lock_state = 0;
      k1_prev = 1'b0; k2_prev = 1'b0;
`ifdef ABORT_EN
      Abort = 1'b0;
`endif
      #12;
      check("rst_outputs", {Key1, Key2, Busy, Done}, 4'h0);
      check("rst_pw",      Password, 4'h0);
      check("rst_cnt",     {Step, Retries}, 4'h0);
      check("rst_fail",    {3'b0, Fail}, 4'h0);
      @(negedge Clk);
      Reset = 1'b0;

      // Correct combination, then a wrong middle code exhausting retries.
      run_seq(4'hD, 4'h7, 4'h9, 0, -1, 0);
      run_seq(4'hD, 4'h6, 4'h9, 0, -1, 0);
      // Lock already open, and lock not at start state.
      run_seq(4'hD, 4'h7, 4'h9, 3, -1, 0);
      run_seq(4'hD, 4'h7, 4'h9, 1, -1, 0);

      // Asynchronous reset mid-PRESS, then a fresh sequence.
      set_lock(0);
      @(negedge Clk);
      Code0 = 4'hD; Code1 = 4'h7; Code2 = 4'h9; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      predict(4'hD, 4'h7, 4'h9, 0, -1);
      repeat (3) @(posedge Clk);
      #2 Reset = 1'b1;
      wave_q.delete();
      #1;
      check("mid_rst_key1", {3'b0, Key1}, 4'h0);
      check("mid_rst_busy", {3'b0, Busy}, 4'h0);
      check("mid_rst_pw",   Password, 4'h0);
      @(posedge Clk);
      #3 Reset = 1'b0;
      run_seq(4'hD, 4'h7, 4'h9, 0, -1, 0);

      // Start and code changes while busy are ignored.
      run_seq(4'hD, 4'h7, 4'h9, 0, -1, 1);

`ifdef ABORT_EN
      // Abort in IDLE does nothing; abort mid-sequence; next Start accepted.
      @(negedge Clk); Abort = 1'b1;
      @(negedge Clk); Abort = 1'b0;
      run_seq(4'hD, 4'h7, 4'h9, 0, 11, 0);
      run_seq(4'hD, 4'h7, 4'h9, 0, 7, 0);
      run_seq(4'hD, 4'h7, 4'h9, 0, -1, 0);
`endif

      // Randomized codes and starting lock states.
      for (int n = 0; n < 20; n++) begin
         r0 = ($urandom_range(0, 1) == 0) ? 4'hD : 4'($urandom);
         r1 = ($urandom_range(0, 1) == 0) ? 4'h7 : 4'($urandom);
         r2 = ($urandom_range(0, 1) == 0) ? 4'h9 : 4'($urandom);
         l0 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_seq(r0, r1, r2, l0, -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
